// File: rtl/rv32i_id_stage.sv
// RV32I decode stage: instruction decode, WB bypass onto operands,
// load-use hazard detection and the ID/EX pipeline register.
module rv32i_id_stage #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  output logic        stall_o,
  input  logic        flush_i,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic [2:0]  ex_funct3,
  output logic        ex_op1_pc,
  output logic        ex_op2_imm,
  output logic        ex_reg_we,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic        ex_is_branch,
  output logic        ex_is_jal,
  output logic        ex_is_jalr,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        op1_pc;
    logic        op2_imm;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } id_ex_t;

  // Bubble: clear valid and every control bit, leave data fields as-is.
  function automatic id_ex_t make_bubble(input id_ex_t s);
    id_ex_t b;
    b           = s;
    b.valid     = 1'b0;
    b.alu_op    = '0;
    b.funct3    = '0;
    b.op1_pc    = 1'b0;
    b.op2_imm   = 1'b0;
    b.reg_we    = 1'b0;
    b.is_load   = 1'b0;
    b.is_store  = 1'b0;
    b.is_branch = 1'b0;
    b.is_jal    = 1'b0;
    b.is_jalr   = 1'b0;
    b.illegal   = 1'b0;
    return b;
  endfunction

  id_ex_t      dec;
  id_ex_t      ex_d, ex_q;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic        hazard;

  assign opcode    = id_instr[6:0];
  assign f3        = id_instr[14:12];
  assign rf_raddr1 = id_instr[19:15];
  assign rf_raddr2 = id_instr[24:20];

  assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                  id_instr[11:8], 1'b0};
  assign imm_u = {id_instr[31:12], 12'b0};
  assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                  id_instr[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    writes_rd  = 1'b0;
    dec.valid  = id_valid;
    dec.pc     = id_pc;
    dec.rs1    = id_instr[19:15];
    dec.rs2    = id_instr[24:20];
    dec.rd     = id_instr[11:7];
    dec.funct3 = f3;
    case (opcode)
      OPC_LUI: begin
        dec.rs1     = '0;
        dec.imm     = imm_u;
        dec.op2_imm = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm     = imm_u;
        dec.op1_pc  = 1'b1;
        dec.op2_imm = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_JAL: begin
        dec.imm     = imm_j;
        dec.op1_pc  = 1'b1;
        dec.op2_imm = 1'b1;
        dec.is_jal  = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_JALR: begin
        dec.imm     = imm_i;
        dec.op2_imm = 1'b1;
        dec.is_jalr = 1'b1;
        writes_rd   = 1'b1;
        uses_rs1    = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm     = imm_i;
        dec.op2_imm = 1'b1;
        dec.is_load = 1'b1;
        writes_rd   = 1'b1;
        uses_rs1    = 1'b1;
      end
      OPC_STORE: begin
        dec.imm      = imm_s;
        dec.op2_imm  = 1'b1;
        dec.is_store = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OPC_OPIMM: begin
        // Only the shift-right immediates carry the alt bit in instr[30].
        dec.imm     = imm_i;
        dec.op2_imm = 1'b1;
        dec.alu_op  = {(f3 == 3'b101) & id_instr[30], f3};
        writes_rd   = 1'b1;
        uses_rs1    = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op = {id_instr[30], f3};
        writes_rd  = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OPC_FENCE: begin
      end
      default: begin
        dec.illegal = 1'b1;
        dec.funct3  = '0;
      end
    endcase
    dec.reg_we = writes_rd && (dec.rd != 5'd0);

    if (dec.rs1 == 5'd0)
      dec.rs1_val = '0;
    else if (WB_BYPASS && wb_we && (wb_waddr == dec.rs1))
      dec.rs1_val = wb_wdata;
    else
      dec.rs1_val = rf_rdata1;

    if (dec.rs2 == 5'd0)
      dec.rs2_val = '0;
    else if (WB_BYPASS && wb_we && (wb_waddr == dec.rs2))
      dec.rs2_val = wb_wdata;
    else
      dec.rs2_val = rf_rdata2;
  end

  assign hazard = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && id_valid &&
                  ((uses_rs1 && (ex_q.rd == dec.rs1)) || (uses_rs2 && (ex_q.rd == dec.rs2)));
  assign stall_o = hazard && !flush_i;

  always_comb begin
    ex_d = dec;
    if (flush_i || hazard || !id_valid)
      ex_d = make_bubble(dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_funct3    = ex_q.funct3;
  assign ex_op1_pc    = ex_q.op1_pc;
  assign ex_op2_imm   = ex_q.op2_imm;
  assign ex_reg_we    = ex_q.reg_we;
  assign ex_is_load   = ex_q.is_load;
  assign ex_is_store  = ex_q.is_store;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_is_jal    = ex_q.is_jal;
  assign ex_is_jalr   = ex_q.is_jalr;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Bench for rv32i_id_stage: decode vector table through a scoreboard queue,
// then hand-written load-use, stall+flush and mid-stall reset sequences.
module tb_rv32i_id_stage;

  logic        clk, rst;
  logic        id_valid, flush_i, wb_we;
  logic [31:0] id_instr, id_pc, wb_wdata, rf_rdata1, rf_rdata2;
  logic [4:0]  wb_waddr, rf_raddr1, rf_raddr2;
  logic        stall_o, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_op1_pc, ex_op2_imm, ex_reg_we, ex_is_load, ex_is_store;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;

  rv32i_id_stage #(.WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .stall_o(stall_o), .flush_i(flush_i), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_op1_pc(ex_op1_pc),
    .ex_op2_imm(ex_op2_imm), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: x1=5, x2=7, others 0x100+index.
  logic [31:0] rf [32];
  initial begin
    rf[0] = 32'd0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    for (int i = 3; i < 32; i++) rf[i] = 32'h100 + i;
  end
  always_comb rf_rdata1 = rf[rf_raddr1];
  always_comb rf_rdata2 = rf[rf_raddr2];

  // ctl = {reg_we, op1_pc, op2_imm, is_load, is_store, is_branch, is_jal, is_jalr, illegal}
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [8:0]  ctl;
    logic        chk1, chk2;
  } exp_t;

  typedef struct {
    logic        v;
    logic [31:0] instr, pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    exp_t        e;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [3:0] alu, input logic [8:0] ctl,
                              input logic c1, input logic c2);
    vec_t t;
    t.v = v; t.instr = instr; t.pc = pc; t.we = we; t.wa = wa; t.wd = wd;
    t.e.valid = v; t.e.pc = pc; t.e.rs1_val = r1; t.e.rs2_val = r2; t.e.imm = imm;
    t.e.rd = rd; t.e.alu = alu; t.e.ctl = ctl; t.e.chk1 = c1; t.e.chk2 = c2;
    return t;
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {ex_reg_we, ex_op1_pc, ex_op2_imm, ex_is_load, ex_is_store,
            ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal};
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    id_valid = v; id_instr = instr; id_pc = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_LW5  = 32'h0000A283;  // LW x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00228333;  // ADD x6,x5,x2
  localparam logic [31:0] I_ADD3 = 32'h002081B3;  // ADD x3,x1,x2

  initial begin
    exp_t e;
    tv[0]  = mk(1, I_ADD3,       32'h1000, 0, 0, 0,            5, 7, 0, 3, 4'b0000, 9'b100000000, 1, 1);
    tv[1]  = mk(1, 32'h00008233, 32'h1004, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 4, 4'b0000, 9'b100000000, 1, 1);
    tv[2]  = mk(1, 32'h00008233, 32'h1008, 1, 0, 32'hDEADBEEF, 5, 0, 0, 4, 4'b0000, 9'b100000000, 1, 1);
    tv[3]  = mk(1, 32'h4030D093, 32'h100C, 0, 0, 0,            5, 32'h103, 32'h403, 1, 4'b1101, 9'b101000000, 1, 1);
    tv[4]  = mk(1, 32'hFE000EE3, 32'h1010, 0, 0, 0,            0, 0, 32'hFFFFFFFC, 0, 4'b0000, 9'b000001000, 1, 1);
    tv[5]  = mk(1, 32'h0000007F, 32'h1014, 0, 0, 0,            0, 0, 0, 0, 4'b0000, 9'b000000001, 1, 1);
    tv[6]  = mk(1, 32'h123453B7, 32'h1018, 0, 0, 0,            0, 0, 32'h12345000, 7, 4'b0000, 9'b101000000, 1, 0);
    tv[7]  = mk(1, 32'h008000EF, 32'h101C, 0, 0, 0,            0, 0, 32'd8, 1, 4'b0000, 9'b111000100, 0, 0);
    tv[8]  = mk(1, 32'h0020A223, 32'h1020, 0, 0, 0,            5, 7, 32'd4, 0, 4'b0000, 9'b001010000, 1, 1);
    tv[9]  = mk(1, 32'hFFC12483, 32'h1024, 0, 0, 0,            7, 0, 32'hFFFFFFFC, 9, 4'b0000, 9'b101100000, 1, 0);
    tv[10] = mk(0, I_ADD3,       32'h1028, 0, 0, 0,            0, 0, 0, 0, 4'b0000, 9'b000000000, 0, 0);
    tv[11] = mk(1, 32'h00008067, 32'h102C, 0, 0, 0,            5, 0, 0, 0, 4'b0000, 9'b001000010, 1, 0);

    rst = 1'b1; flush_i = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    drive(0, 32'h0, 32'h0);
    #12;
    chk("reset_valid", {31'd0, ex_valid}, 0);
    chk("reset_ctl", {23'd0, dut_ctl()}, 0);
    chk("reset_pc", ex_pc, 0);
    chk("reset_stall", {31'd0, stall_o}, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].instr, tv[i].pc);
      wb_we = tv[i].we; wb_waddr = tv[i].wa; wb_wdata = tv[i].wd;
      sb_q.push_back(tv[i].e);
      #1;
      chk($sformatf("raddr1_%0d", i), {27'd0, rf_raddr1}, {27'd0, tv[i].instr[19:15]});
      chk($sformatf("raddr2_%0d", i), {27'd0, rf_raddr2}, {27'd0, tv[i].instr[24:20]});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      chk($sformatf("valid_%0d", i), {31'd0, ex_valid}, {31'd0, e.valid});
      chk($sformatf("ctl_%0d", i), {23'd0, dut_ctl()}, {23'd0, e.ctl});
      chk($sformatf("alu_%0d", i), {28'd0, ex_alu_op}, {28'd0, e.alu});
      if (e.valid) begin
        chk($sformatf("pc_%0d", i), ex_pc, e.pc);
        chk($sformatf("imm_%0d", i), ex_imm, e.imm);
        if (e.chk1) chk($sformatf("rs1val_%0d", i), ex_rs1_val, e.rs1_val);
        if (e.chk2) chk($sformatf("rs2val_%0d", i), ex_rs2_val, e.rs2_val);
        if (e.ctl[8]) chk($sformatf("rd_%0d", i), {27'd0, ex_rd}, {27'd0, e.rd});
      end
    end
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;

    // Load-use: exactly one bubble, dependent ADD enters EX the cycle after.
    @(negedge clk); drive(1, I_LW5, 32'h2000);
    @(posedge clk); #1;
    chk("lu_load_in_ex", {31'd0, ex_is_load}, 1);
    drive(1, I_ADD6, 32'h2004); #1;
    chk("lu_stall", {31'd0, stall_o}, 1);
    @(posedge clk); #1;
    chk("lu_bubble_valid", {31'd0, ex_valid}, 0);
    chk("lu_bubble_ctl", {23'd0, dut_ctl()}, 0);
    chk("lu_stall_released", {31'd0, stall_o}, 0);
    @(posedge clk); #1;
    chk("lu_add_valid", {31'd0, ex_valid}, 1);
    chk("lu_add_rd", {27'd0, ex_rd}, 6);
    chk("lu_add_rs1val", ex_rs1_val, 32'h105);
    chk("lu_add_pc", ex_pc, 32'h2004);

    // Stall and flush together: flush wins, bubble enters.
    @(negedge clk); drive(1, I_LW5, 32'h3000);
    @(posedge clk); #1;
    drive(1, I_ADD6, 32'h3004); flush_i = 1'b1; #1;
    chk("fl_stall", {31'd0, stall_o}, 0);
    @(posedge clk); #1;
    chk("fl_valid", {31'd0, ex_valid}, 0);
    chk("fl_ctl", {23'd0, dut_ctl()}, 0);
    flush_i = 1'b0;

    // Reset mid-stall clears ID/EX without a clock edge.
    @(negedge clk); drive(1, I_LW5, 32'h4000);
    @(posedge clk); #1;
    drive(1, I_ADD6, 32'h4004); #1;
    chk("rs_stall_before", {31'd0, stall_o}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid", {31'd0, ex_valid}, 0);
    chk("rs_ctl", {23'd0, dut_ctl()}, 0);
    chk("rs_pc", ex_pc, 0);
    chk("rs_rd", {27'd0, ex_rd}, 0);
    chk("rs_stall", {31'd0, stall_o}, 0);
    @(negedge clk); rst = 1'b0;
    drive(1, I_ADD3, 32'h5000);
    @(posedge clk); #1;
    chk("rs_resume_valid", {31'd0, ex_valid}, 1);
    chk("rs_resume_rd", {27'd0, ex_rd}, 3);
    chk("rs_resume_rs2val", ex_rs2_val, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
